// File: rtl/wrap_event_logger.sv
// Timestamps each wrap (0 -> all-ones) of an upstream down counter into a small FIFO.
// Optional illegal-step detection is compiled in with `define WRAP_LOGGER_STEP_CHECK_EN.
module wrap_event_logger #(
    parameter int N     = 3,
    parameter int DEPTH = 4,
    parameter int TS_W  = 16
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic [N-1:0]             i_count,
    input  logic                     i_evt_ready,
    output logic                     o_evt_valid,
    output logic [TS_W-1:0]          o_evt_data,
    output logic                     o_wrap_pulse,
    output logic [$clog2(DEPTH):0]   o_fill,
    output logic                     o_overflow,
    output logic                     o_step_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam logic [FW-1:0] FULL_LVL = FW'(DEPTH);
    localparam logic [N-1:0]  CNT_MAX  = '1;

    logic [TS_W-1:0] r_ts;
    logic [N-1:0]    r_prev;
    logic            r_prev_vld;
    logic            r_wrap_pulse;
    logic [TS_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [FW-1:0]   r_fill;
    logic            r_overflow;

    logic w_wrap;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_wrap = r_prev_vld && (r_prev == '0) && (i_count == CNT_MAX);
    assign w_full = (r_fill == FULL_LVL);
    assign w_pop  = (r_fill != '0) && i_evt_ready;
    // A pop on the same edge frees the slot, so a full buffer still accepts.
    assign w_push = w_wrap && (!w_full || w_pop);
    assign w_drop = w_wrap && w_full && !w_pop;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_ts         <= '0;
            r_prev       <= '0;
            r_prev_vld   <= 1'b0;
            r_wrap_pulse <= 1'b0;
        end else begin
            r_ts         <= r_ts + TS_W'(1);
            r_prev       <= i_count;
            r_prev_vld   <= 1'b1;
            r_wrap_pulse <= w_wrap;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fill     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + FW'(1);
                2'b01:   r_fill <= r_fill - FW'(1);
                default: r_fill <= r_fill;
            endcase
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset && w_push) r_mem[r_wr_ptr] <= r_ts;
    end

`ifdef WRAP_LOGGER_STEP_CHECK_EN
    logic r_step_err;
    logic w_step_bad;

    // Legal moves: hold, decrement by one, or the 0 -> all-ones wrap.
    assign w_step_bad = r_prev_vld && (i_count != r_prev)
                        && (i_count != (r_prev - N'(1))) && !w_wrap;

    always_ff @(posedge i_clock) begin
        if (!i_reset)        r_step_err <= 1'b0;
        else if (w_step_bad) r_step_err <= 1'b1;
    end

    assign o_step_err = r_step_err;
`else
    assign o_step_err = 1'b0;
`endif

    assign o_evt_valid  = (r_fill != '0);
    assign o_evt_data   = r_mem[r_rd_ptr];
    assign o_wrap_pulse = r_wrap_pulse;
    assign o_fill       = r_fill;
    assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_wrap_event_logger.sv
// Randomized and directed bench for wrap_event_logger against a queue-based reference model.
module tb_wrap_event_logger;

    localparam int N     = 3;
    localparam int DEPTH = 4;
    localparam int TS_W  = 16;
    localparam int FW    = $clog2(DEPTH) + 1;
    localparam int CMOD  = 1 << N;
    localparam int CMAX  = CMOD - 1;

    logic            clk = 1'b0;
    logic            i_reset;
    logic [N-1:0]    i_count;
    logic            i_evt_ready;
    logic            o_evt_valid;
    logic [TS_W-1:0] o_evt_data;
    logic            o_wrap_pulse;
    logic [FW-1:0]   o_fill;
    logic            o_overflow;
    logic            o_step_err;

    always #5 clk = ~clk;

    wrap_event_logger #(.N(N), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .i_clock      (clk),
        .i_reset      (i_reset),
        .i_count      (i_count),
        .i_evt_ready  (i_evt_ready),
        .o_evt_valid  (o_evt_valid),
        .o_evt_data   (o_evt_data),
        .o_wrap_pulse (o_wrap_pulse),
        .o_fill       (o_fill),
        .o_overflow   (o_overflow),
        .o_step_err   (o_step_err)
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_ts;
    int m_prev;
    bit m_prev_vld;
    bit m_pulse;
    bit m_ovf;
    bit m_step;
    int q[$];
    int cur_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("evt_valid", 32'(o_evt_valid), 32'(q.size() != 0));
        if (q.size() != 0) check("evt_data", 32'(o_evt_data), 32'(q[0]));
        check("fill", 32'(o_fill), 32'(q.size()));
        check("wrap_pulse", 32'(o_wrap_pulse), 32'(m_pulse));
        check("overflow", 32'(o_overflow), 32'(m_ovf));
        check("step_err", 32'(o_step_err), 32'(m_step));
    endtask

    task automatic step(input int cnt, input bit rdy, input bit rst_n);
        bit wrap;
        bit pop;
        int sz;
        cur_cnt     = cnt % CMOD;
        i_count     = cur_cnt[N-1:0];
        i_evt_ready = rdy;
        i_reset     = rst_n;
        @(posedge clk);
        if (!rst_n) begin
            m_ts = 0; m_prev = 0; m_prev_vld = 0; m_pulse = 0;
            m_ovf = 0; m_step = 0; q.delete();
        end else begin
            wrap = m_prev_vld && (m_prev == 0) && (cur_cnt == CMAX);
`ifdef WRAP_LOGGER_STEP_CHECK_EN
            if (m_prev_vld && cur_cnt != m_prev && cur_cnt != (m_prev + CMAX) % CMOD && !wrap)
                m_step = 1;
`endif
            sz  = q.size();
            pop = (sz > 0) && rdy;
            if (pop) void'(q.pop_front());
            if (wrap) begin
                if (sz < DEPTH || pop) q.push_back(m_ts);
                else m_ovf = 1;
            end
            m_pulse    = wrap;
            m_ts       = (m_ts + 1) % (1 << TS_W);
            m_prev     = cur_cnt;
            m_prev_vld = 1;
        end
        #1;
        compare_all();
    endtask

    // n full down-count laps starting from 6 (prev must already be 7)
    task automatic laps(input int n, input bit rdy_last);
        for (int w = 0; w < n; w++) begin
            for (int v = 6; v >= 0; v--) step(v, 1'b0, 1'b1);
            step(7, rdy_last, 1'b1);
        end
    endtask

    initial begin
        int thr;
        int r;
        i_reset = 1'b0; i_count = '0; i_evt_ready = 1'b0;
        step(0, 0, 0);
        step(0, 0, 0);
        check("reset_fill", 32'(o_fill), 32'd0);
        check("reset_pulse", 32'(o_wrap_pulse), 32'd0);

        // single wrap: 7..0,7 with consumer stalled
        for (int v = 7; v >= 0; v--) step(v, 0, 1);
        step(7, 0, 1);
        check("r032_pulse", 32'(o_wrap_pulse), 32'd1);
        check("r032_fill", 32'(o_fill), 32'd1);
        check("r032_data", 32'(o_evt_data), 32'd8);
        step(6, 0, 1);
        check("r032_pulse_once", 32'(o_wrap_pulse), 32'd0);

        // five wraps into a 4-deep buffer
        laps(4, 0);
        check("r033_fill", 32'(o_fill), 32'd4);
        check("r033_ovf", 32'(o_overflow), 32'd1);
        check("r033_head", 32'(o_evt_data), 32'd8);

        // full buffer, wrap coincident with a pop
        step(0, 0, 0);
        step(7, 0, 1);
        laps(4, 0);
        laps(1, 1);
        check("r034_fill", 32'(o_fill), 32'd4);
        check("r034_ovf", 32'(o_overflow), 32'd0);
        check("r034_head", 32'(o_evt_data), 32'd16);

        // toggling ready drains in order
        for (int i = 0; i < 12; i++) step(7, i[0], 1);
        check("r037_empty", 32'(o_evt_valid), 32'd0);

        // reset with fill=3, then 7 right after a pre-reset 0
        step(0, 0, 0);
        step(7, 0, 1);
        laps(3, 0);
        for (int v = 6; v >= 0; v--) step(v, 0, 1);
        check("r035_pre_fill", 32'(o_fill), 32'd3);
        step(0, 0, 0);
        check("r035_valid", 32'(o_evt_valid), 32'd0);
        check("r035_fill", 32'(o_fill), 32'd0);
        step(7, 0, 1);
        check("r035_no_wrap", 32'(o_wrap_pulse), 32'd0);

        // step checking
        step(0, 0, 0);
        step(5, 0, 1);
        step(2, 0, 1);
`ifdef WRAP_LOGGER_STEP_CHECK_EN
        check("r036_jump", 32'(o_step_err), 32'd1);
`else
        check("r036_jump", 32'(o_step_err), 32'd0);
`endif
        step(0, 0, 0);
        step(5, 0, 1);
        step(5, 0, 1);
        step(4, 0, 1);
        check("r036_legal", 32'(o_step_err), 32'd0);

        // randomized traffic
        thr = 50;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) thr = $urandom_range(0, 100);
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 199) == 0)
                step(cur_cnt, 0, 0);
            else if (r < 75)
                step((cur_cnt + CMAX) % CMOD, $urandom_range(0, 99) < thr, 1);
            else if (r < 97)
                step(cur_cnt, $urandom_range(0, 99) < thr, 1);
            else
                step($urandom_range(0, CMAX), $urandom_range(0, 99) < thr, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
